sysid_verifier: RTL and testbench
=================================

# sysid_verifier

Avalon-MM master that reads the two-word system ID slave (word 0 = system ID, word 1 = build timestamp) after reset or on request. It compares both words against build-time expected values and publishes pass/fail status. It sits directly downstream of the sysid slave on the Qsys fabric, so the HDMI TX pipeline can be held off until the loaded image is confirmed to match the software build.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_0000: required value of word 0.
- EXPECTED_TIMESTAMP, 32'h550B_D444: required value of word 1.
- CHECK_TIMESTAMP, 1: 1 = word 1 must match; 0 = ts_ok forced 1.
- AUTO_START, 1: 1 = a check starts automatically after reset release.
- TIMEOUT_CYCLES, 255: per-read cycle limit (range 1..65535).

Ports (one clock; reset is asynchronous and active-high):
- clock, in, 1: system clock; all logic is rising-edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- start, in, 1: single-cycle request to (re)run a check; ignored while busy.
- avm_address, out, 1: word select (0 = ID, 1 = timestamp).
- avm_read, out, 1: read request.
- avm_waitrequest, in, 1: slave stall; the request is held while high.
- avm_readdata, in, 32: read data, qualified by avm_readdatavalid.
- avm_readdatavalid, in, 1: read response valid.
- busy, out, 1: a check is in progress.
- done, out, 1: status outputs are valid (level; cleared when a new check starts).
- id_ok, out, 1: captured ID equals EXPECTED_ID.
- ts_ok, out, 1: captured timestamp equals EXPECTED_TIMESTAMP (or 1 if CHECK_TIMESTAMP = 0).
- pass, out, 1: id_ok & ts_ok & !timeout.
- timeout, out, 1: a read exceeded TIMEOUT_CYCLES.
- sysid_value, out, 32: last captured word 0.
- timestamp_value, out, 32: last captured word 1.

## Operation
- Reset values: every output is 0 and the FSM is in IDLE. The timeout counter is 0.
- FSM states: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, DONE.
- IDLE → RD_ID_REQ:
  - on the first cycle after reset deasserts, if AUTO_START = 1;
  - otherwise on start = 1.
- DONE → RD_ID_REQ on start = 1.
- Entering RD_ID_REQ:
  - clears done, id_ok, ts_ok, pass and timeout;
  - sets busy.
- *_REQ states:
  - avm_read = 1; avm_address = 0 (ID) or 1 (TS).
  - Both signals stay stable while avm_waitrequest = 1.
  - The request is accepted on the edge where avm_waitrequest = 0, then the FSM moves to the matching *_WAIT state.
- *_WAIT states:
  - avm_read = 0.
  - On avm_readdatavalid = 1, capture avm_readdata into sysid_value (ID) or timestamp_value (TS).
  - RD_ID_WAIT then goes to RD_TS_REQ; RD_TS_WAIT then goes to DONE.
- Only one read is ever outstanding.
- avm_readdatavalid is ignored in IDLE, DONE and the *_REQ states.
- Timeout:
  - The counter clears on entry to each *_REQ state and increments every cycle in *_REQ/*_WAIT.
  - When it reaches TIMEOUT_CYCLES, set timeout = 1, drop avm_read and go to DONE.
  - A late readdatavalid arriving after this is ignored.
- Entering DONE:
  - register id_ok, ts_ok and pass from the captured values;
  - set done = 1 and busy = 0.
  - Status holds until the next check starts or reset.
- start asserted while busy = 1: ignored (no queueing).
- Reset asserted mid-read: all state clears immediately and avm_read drops asynchronously. With AUTO_START = 1 a fresh check runs after release.

## Timing
- Zero-wait slave, readdatavalid one cycle after acceptance:
  - cycle 0: trigger;
  - cycle 1: RD_ID_REQ, read accepted;
  - cycle 2: ID captured;
  - cycle 3: RD_TS_REQ accepted;
  - cycle 4: timestamp captured;
  - cycle 5: DONE, with done/pass valid from cycle 5 onward.
- Total latency is 5 cycles plus the sum of waitrequest stall cycles and extra response latency.
- Timeout is asserted exactly TIMEOUT_CYCLES cycles after entry to the stalled *_REQ state.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Zero-wait slave returning 0x00000000 / 0x550BD444, defaults, AUTO_START = 1:
  - avm_read pulses at cycles 1 and 3 with addresses 0 then 1;
  - done = pass = id_ok = ts_ok = 1 at cycle 5; sysid_value = 0, timestamp_value = 0x550BD444.
- Slave returns ID 0x00000001:
  - id_ok = 0, pass = 0, ts_ok = 1, sysid_value = 0x00000001.
- With CHECK_TIMESTAMP = 0, slave returns timestamp 0x12345678:
  - ts_ok = 1, pass = 1.
- waitrequest held high for 3 cycles on each read, readdatavalid 2 cycles after acceptance:
  - address/read stay stable during the stall;
  - done at cycle 13; pass = 1.
- TIMEOUT_CYCLES = 8, waitrequest stuck high:
  - timeout = 1, pass = 0, done = 1 exactly 8 cycles after RD_ID_REQ entry; avm_read = 0 afterwards.
- start pulsed while busy: no effect. Reset asserted during RD_TS_WAIT:
  - all outputs are 0 immediately;
  - after release, a full check reruns and passes; start in DONE reruns with done low during the rerun.

Source files
------------

// File: rtl/sysid_verifier.sv
// sysid_verifier: Avalon-MM master that reads the two-word system ID slave
// (word 0 = system ID, word 1 = build timestamp), compares both words
// against build-time constants and publishes registered pass/fail status.
// Downstream logic (the HDMI TX pipeline) can gate on done & pass.
module sysid_verifier #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h550B_D444,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] sysid_value,
  output logic [31:0] timestamp_value
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID_REQ  = 3'd1,
    S_ID_WAIT = 3'd2,
    S_TS_REQ  = 3'd3,
    S_TS_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // The counter expires on the cycle it would reach TIMEOUT_CYCLES, so the
  // timeout flag becomes visible exactly TIMEOUT_CYCLES cycles after entry.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] sysid_q, sysid_d;
  logic [31:0] ts_q, ts_d;
  logic [15:0] cnt_q, cnt_d;
  logic        auto_q, auto_d;
  logic        start_check_s;
  logic        finish_s;
  logic        expire_s;

  // Next-state, bus request and status computation.
  always_comb begin
    state_d       = state_q;
    read_d        = read_q;
    addr_d        = addr_q;
    busy_d        = busy_q;
    done_d        = done_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    sysid_d       = sysid_q;
    ts_d          = ts_q;
    cnt_d         = cnt_q;
    auto_d        = auto_q;
    start_check_s = 1'b0;
    finish_s      = 1'b0;
    expire_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (auto_q || start) begin
          start_check_s = 1'b1;
        end else begin
          start_check_s = 1'b0;
        end
      end
      S_ID_REQ, S_TS_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q >= TO_LAST) begin
          expire_s = 1'b1;
        end else if (!avm_waitrequest) begin
          // Request accepted on this edge; wait for the single response.
          read_d  = 1'b0;
          state_d = (state_q == S_ID_REQ) ? S_ID_WAIT : S_TS_WAIT;
        end else begin
          read_d = 1'b1;
        end
      end
      S_ID_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q >= TO_LAST) begin
          expire_s = 1'b1;
        end else if (avm_readdatavalid) begin
          sysid_d = avm_readdata;
          state_d = S_TS_REQ;
          read_d  = 1'b1;
          addr_d  = 1'b1;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_ID_WAIT;
        end
      end
      S_TS_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q >= TO_LAST) begin
          expire_s = 1'b1;
        end else if (avm_readdatavalid) begin
          ts_d     = avm_readdata;
          finish_s = 1'b1;
        end else begin
          state_d = S_TS_WAIT;
        end
      end
      S_DONE: begin
        if (start) begin
          start_check_s = 1'b1;
        end else begin
          start_check_s = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (start_check_s) begin
      state_d   = S_ID_REQ;
      read_d    = 1'b1;
      addr_d    = 1'b0;
      cnt_d     = 16'd0;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
      auto_d    = 1'b0;
    end else begin
      auto_d = auto_q;
    end

    if (finish_s || expire_s) begin
      // Status is judged on the values as they stand after this edge, so a
      // timestamp captured on the final edge is already taken into account.
      state_d   = S_DONE;
      read_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      timeout_d = expire_s;
      id_ok_d   = (sysid_d == EXPECTED_ID);
      ts_ok_d   = !CHECK_TIMESTAMP || (ts_d == EXPECTED_TIMESTAMP);
      pass_d    = id_ok_d && ts_ok_d && !expire_s;
    end else begin
      timeout_d = timeout_d;
    end
  end

  // State and output registers; reset clears everything and arms auto-start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      read_q    <= 1'b0;
      addr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      sysid_q   <= 32'h0000_0000;
      ts_q      <= 32'h0000_0000;
      cnt_q     <= 16'd0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      sysid_q   <= sysid_d;
      ts_q      <= ts_d;
      cnt_q     <= cnt_d;
      auto_q    <= auto_d;
    end
  end

  assign avm_address     = addr_q;
  assign avm_read        = read_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign pass            = pass_q;
  assign timeout         = timeout_q;
  assign sysid_value     = sysid_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_sysid_verifier.sv
// Testbench for sysid_verifier: a reactive sysid slave model drives three
// instances (defaults, timestamp check disabled, 8-cycle timeout); expected
// results are queued at each trigger and compared when done rises.
module tb_sysid_verifier;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        waitrequest = 1'b0;
  logic        rdv = 1'b0;
  logic [31:0] readdata = 32'h0000_0000;

  logic        m_addr, m_read, m_busy, m_done, m_id_ok, m_ts_ok, m_pass, m_timeout;
  logic [31:0] m_sysid, m_ts;
  logic        n_addr, n_read, n_busy, n_done, n_id_ok, n_ts_ok, n_pass, n_timeout;
  logic [31:0] n_sysid, n_ts;
  logic        t_addr, t_read, t_busy, t_done, t_id_ok, t_ts_ok, t_pass, t_timeout;
  logic [31:0] t_sysid, t_ts;

  sysid_verifier dut_m (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(m_addr), .avm_read(m_read), .avm_waitrequest(waitrequest),
    .avm_readdata(readdata), .avm_readdatavalid(rdv),
    .busy(m_busy), .done(m_done), .id_ok(m_id_ok), .ts_ok(m_ts_ok),
    .pass(m_pass), .timeout(m_timeout), .sysid_value(m_sysid), .timestamp_value(m_ts)
  );

  sysid_verifier #(.CHECK_TIMESTAMP(1'b0)) dut_n (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(n_addr), .avm_read(n_read), .avm_waitrequest(waitrequest),
    .avm_readdata(readdata), .avm_readdatavalid(rdv),
    .busy(n_busy), .done(n_done), .id_ok(n_id_ok), .ts_ok(n_ts_ok),
    .pass(n_pass), .timeout(n_timeout), .sysid_value(n_sysid), .timestamp_value(n_ts)
  );

  sysid_verifier #(.TIMEOUT_CYCLES(8)) dut_t (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(t_addr), .avm_read(t_read), .avm_waitrequest(waitrequest),
    .avm_readdata(readdata), .avm_readdatavalid(rdv),
    .busy(t_busy), .done(t_done), .id_ok(t_id_ok), .ts_ok(t_ts_ok),
    .pass(t_pass), .timeout(t_timeout), .sysid_value(t_sysid), .timestamp_value(t_ts)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        pass;
    logic        n_pass;
    logic [31:0] sysid;
    logic [31:0] ts;
  } exp_t;
  exp_t sb[$];

  // Slave model configuration and state.
  logic [31:0] id_word = 32'h0000_0000;
  logic [31:0] ts_word = 32'h550B_D444;
  int          stall = 0;
  int          lat = 1;
  bit          stuck = 1'b0;
  bit          pending = 1'b0;
  int          lat_cnt = 0;
  logic        pend_addr = 1'b0;
  logic        prev_read = 1'b0;
  logic        prev_addr = 1'b0;
  int          age = 0;
  logic        m_done_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.id_ok  = (id_word == 32'h0000_0000);
    e.ts_ok  = (ts_word == 32'h550B_D444);
    e.pass   = e.id_ok && e.ts_ok;
    e.n_pass = e.id_ok;
    e.sysid  = id_word;
    e.ts     = ts_word;
    return e;
  endfunction

  task automatic set_slave(input logic [31:0] id, input logic [31:0] ts,
                           input int st, input int lt, input bit sk);
    id_word = id; ts_word = ts; stall = st; lat = lt; stuck = sk;
  endtask

  // Called once per cycle at the falling edge: reacts to what the DUT did on
  // the previous rising edge and drives inputs for the next one.
  task automatic slave_update();
    if (prev_read && !waitrequest) begin
      pending = 1'b1; lat_cnt = lat; pend_addr = prev_addr;
    end
    rdv = 1'b0;
    readdata = 32'hDEAD_BEEF;
    if (pending) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        rdv = 1'b1;
        readdata = pend_addr ? ts_word : id_word;
        pending = 1'b0;
      end
    end
    if (m_read) age = prev_read ? age + 1 : 0;
    waitrequest = stuck || (m_read && (age < stall));
    prev_read = m_read;
    prev_addr = m_addr;
  endtask

  task automatic sb_check();
    exp_t e;
    if (m_done && !m_done_prev) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("id_ok", 32'(m_id_ok), 32'(e.id_ok));
        chk("ts_ok", 32'(m_ts_ok), 32'(e.ts_ok));
        chk("pass", 32'(m_pass), 32'(e.pass));
        chk("timeout", 32'(m_timeout), 32'd0);
        chk("busy_at_done", 32'(m_busy), 32'd0);
        chk("sysid_value", m_sysid, e.sysid);
        chk("timestamp_value", m_ts, e.ts);
        chk("n_ts_ok", 32'(n_ts_ok), 32'd1);
        chk("n_pass", 32'(n_pass), 32'(e.n_pass));
        chk("n_done", 32'(n_done), 32'd1);
      end
    end
    m_done_prev = m_done;
  endtask

  task automatic tick();
    @(negedge clock);
    start = 1'b0;
    cyc++;
    slave_update();
    sb_check();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_ctl"}, {24'd0, m_addr, m_read, m_busy, m_done, m_id_ok, m_ts_ok, m_pass, m_timeout}, 32'd0);
    chk({tag, "_m_sysid"}, m_sysid, 32'd0);
    chk({tag, "_m_ts"}, m_ts, 32'd0);
    chk({tag, "_t_ctl"}, {24'd0, t_addr, t_read, t_busy, t_done, t_id_ok, t_ts_ok, t_pass, t_timeout}, 32'd0);
  endtask

  // Asserts reset now, holds it, then releases at a falling edge (cycle 0).
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_zero("rst_now");
    sb.delete();
    pending = 1'b0; prev_read = 1'b0; prev_addr = 1'b0; age = 0;
    rdv = 1'b0; waitrequest = 1'b0; m_done_prev = 1'b0;
    repeat (2) @(negedge clock);
    check_zero("rst_hold");
    reset = 1'b0;
    cyc = 0;
    sb.push_back(predict());
    slave_update();
  endtask

  task automatic pulse_start(input bit expect_result);
    start = 1'b1;
    cyc = 0;
    if (expect_result) sb.push_back(predict());
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!m_done && k < budget) begin
      tick();
      k++;
    end
    chk("done_within_budget", 32'(m_done), 32'd1);
  endtask

  initial begin
    // 1: reset state and auto-start with a zero-wait slave.
    set_slave(32'h0000_0000, 32'h550B_D444, 0, 1, 1'b0);
    #2;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      tick();
      case (i)
        1: begin chk("c1_read", 32'(m_read), 32'd1); chk("c1_addr", 32'(m_addr), 32'd0);
                 chk("c1_busy", 32'(m_busy), 32'd1); end
        2: chk("c2_read", 32'(m_read), 32'd0);
        3: begin chk("c3_read", 32'(m_read), 32'd1); chk("c3_addr", 32'(m_addr), 32'd1); end
        4: begin chk("c4_read", 32'(m_read), 32'd0); chk("c4_done", 32'(m_done), 32'd0); end
        5: chk("c5_done", 32'(m_done), 32'd1);
        default: chk("c6_done_held", 32'(m_done), 32'd1);
      endcase
    end

    // 2: wrong ID.
    set_slave(32'h0000_0001, 32'h550B_D444, 0, 1, 1'b0);
    pulse_start(1'b1);
    tick();
    chk("rerun_done_low", 32'(m_done), 32'd0);
    wait_done(20);
    chk("s2_latency", 32'(cyc), 32'd5);

    // 3: wrong timestamp (only the checking instance cares).
    set_slave(32'h0000_0000, 32'h1234_5678, 0, 1, 1'b0);
    pulse_start(1'b1);
    tick();
    wait_done(20);
    chk("s3_latency", 32'(cyc), 32'd5);

    // 4: 3-cycle stall per read, response 2 cycles after acceptance,
    //    plus a start pulse while busy.
    set_slave(32'h0000_0000, 32'h550B_D444, 3, 2, 1'b0);
    pulse_start(1'b1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i >= 1 && i <= 4) begin
        chk("stall_id_read", 32'(m_read), 32'd1); chk("stall_id_addr", 32'(m_addr), 32'd0);
      end
      if (i >= 7 && i <= 10) begin
        chk("stall_ts_read", 32'(m_read), 32'd1); chk("stall_ts_addr", 32'(m_addr), 32'd1);
      end
      if (i == 6) start = 1'b1;
      if (i == 12) chk("stall_c12_done", 32'(m_done), 32'd0);
      if (i == 13) chk("stall_c13_done", 32'(m_done), 32'd1);
      if (i >= 14) begin
        chk("busy_start_ignored", {29'd0, m_done, m_busy, m_read}, 32'd4);
      end
    end

    // 5: waitrequest stuck high; 8-cycle instance times out.
    set_slave(32'h0000_0000, 32'h550B_D444, 0, 1, 1'b1);
    pulse_start(1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 8) begin
        chk("to_c8_done", 32'(t_done), 32'd0); chk("to_c8_read", 32'(t_read), 32'd1);
      end
      if (i == 9) begin
        chk("to_c9_done", 32'(t_done), 32'd1); chk("to_c9_timeout", 32'(t_timeout), 32'd1);
        chk("to_c9_pass", 32'(t_pass), 32'd0); chk("to_c9_busy", 32'(t_busy), 32'd0);
      end
      if (i > 9) chk("to_read_dropped", 32'(t_read), 32'd0);
    end
    chk("main_still_busy", 32'(m_busy), 32'd1);

    // 6: reset during RD_TS_WAIT, rerun after release, then start from DONE.
    set_slave(32'h0000_0000, 32'h550B_D444, 0, 5, 1'b0);
    do_reset();
    wait_done(40);
    chk("slow_latency", 32'(cyc), 32'd13);
    pulse_start(1'b1);
    for (int i = 1; i <= 9; i++) tick();
    chk("ts_wait_state", {29'd0, m_busy, m_read, m_addr}, 32'd5);
    set_slave(32'h0000_0000, 32'h550B_D444, 0, 1, 1'b0);
    do_reset();
    wait_done(20);
    chk("after_rst_latency", 32'(cyc), 32'd5);
    pulse_start(1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rerun2_done_low", 32'(m_done), 32'd0);
    end
    wait_done(20);
    chk("rerun2_latency", 32'(cyc), 32'd5);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
